mult_wb_stage: RTL and testbench
================================

MULT_WB_STAGE -- requirements
Module: mult_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter REG_W, default 5, destination register index width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, output buffer entries; power of two, >=2.
REQ-004 SHALL have port clock  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1  upstream result present.
REQ-007 SHALL have port in_ready  out  1  stage can accept this cycle.
REQ-008 SHALL have port in_mode  in  2  operation: MUL, MULH, MULU, RSVD.
REQ-009 SHALL have port in_product  in  2*DATA_W  unsigned product magnitude.
REQ-010 SHALL have port in_regdest  in  REG_W  destination register.
REQ-011 SHALL have port in_negative  in  1  true result is negative (signed modes).
REQ-012 SHALL have port in_zero  in  1  an operand was zero.
REQ-013 SHALL have port out_valid  out  1  head entry valid.
REQ-014 SHALL have port out_ready  in  1  writeback port consumes head.
REQ-015 SHALL have ports out_regdest (REG_W), out_writereg (1), out_value (DATA_W), out_overflow (1)  out  head entry fields.
REQ-016 SHALL have port ovf_clear  in  1  synchronous clear of ovf_count.
REQ-017 SHALL have port ovf_count  out  16  saturating count of overflow entries.

Function
REQ-018 Accept SHALL occur when in_valid && in_ready; in_ready SHALL equal !full, with no combinational path from out_ready.
REQ-019 Accepted result SHALL be written into the FIFO on the accepting edge; out_valid SHALL rise the following cycle (latency 1).
REQ-020 R SHALL be -in_product (2*DATA_W two's complement) when in_negative, else in_product.
REQ-021 MUL: value=R[DATA_W-1:0]; overflow when R[2*DATA_W-1:DATA_W-1] is not all-equal.
REQ-022 MULH: value=R[2*DATA_W-1:DATA_W]; overflow never.
REQ-023 MULU: value=in_product[DATA_W-1:0], in_negative ignored; overflow when in_product[2*DATA_W-1:DATA_W]!=0.
REQ-024 Overflow entry SHALL have writereg=0, regdest=0, value=0, overflow=1.
REQ-025 RSVD SHALL push an entry with writereg=0, regdest=0, value=0, overflow=0.
REQ-026 in_zero (non-RSVD) SHALL force value=0, overflow=0, writereg=1, overriding in_negative and in_product.
REQ-027 Non-overflow, non-RSVD entries SHALL have writereg=1, regdest=in_regdest.
REQ-028 Pop SHALL occur when out_valid && out_ready; entries SHALL leave in acceptance order.
REQ-029 Simultaneous push and pop SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 When empty, out_valid=0 and all out_* fields SHALL read 0.
REQ-031 ovf_count SHALL increment on each accepted overflow entry, saturate at 0xFFFF; ovf_clear SHALL take precedence (result 0).

Reset
REQ-032 While reset=0: FIFO pointers/occupancy 0, out_valid=0, all out_* 0, ovf_count=0, in_ready=0.
REQ-033 in_ready SHALL be 1 the first cycle after reset release.
REQ-034 Reset mid-operation SHALL discard all buffered entries immediately.

Structure
REQ-035 Shared package mult_pkg SHALL hold mode encodings (MUL=00, MULH=01, MULU=10, RSVD=11) and the writeback entry struct (regdest, writereg, value, overflow).
REQ-036 Buffer SHALL be sub-module mult_wb_fifo (synchronous, parametrised width/depth, full/empty outputs); sign/overflow logic SHALL stay in mult_wb_stage.

Verification (DATA_W=32, FIFO_DEPTH=2)
REQ-037 MUL, product=42, positive, regdest=3 -> next cycle out_valid=1, value=0x0000002A, writereg=1, regdest=3, overflow=0.
REQ-038 MUL, product=0x80000000: negative -> value 0x80000000, overflow=0; positive -> overflow=1, writereg=0, ovf_count=1.
REQ-039 MULH, product=1, negative -> value 0xFFFFFFFF; MULU product=0x1_00000000 -> overflow=1; in_zero with negative -> value 0, writereg=1.
REQ-040 out_ready=0, push A,B -> in_ready=0, C held; out_ready=1 -> A,B,C delivered in order, simultaneous push/pop keeps occupancy.
REQ-041 One entry buffered, reset pulsed -> out_valid=0 immediately, ovf_count=0; ovf_clear during an overflow accept -> ovf_count=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the multiplier writeback stage:
// operation encodings and the buffered writeback entry.
package mult_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_REG_W  = 5;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'b00,
        MODE_MULH = 2'b01,
        MODE_MULU = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef struct packed {
        logic [WB_REG_W-1:0]  regdest;
        logic                 writereg;
        logic [WB_DATA_W-1:0] value;
        logic                 overflow;
    } wb_entry_t;

endpackage

// File: rtl/mult_wb_stage_if.sv
// Handshake bundle between the multiplier, the writeback
// stage and the register-file write port.
interface mult_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_mode;
    logic [2*DATA_W-1:0]   in_product;
    logic [REG_W-1:0]      in_regdest;
    logic                  in_negative;
    logic                  in_zero;

    logic                  out_valid;
    logic                  out_ready;
    logic [REG_W-1:0]      out_regdest;
    logic                  out_writereg;
    logic [DATA_W-1:0]     out_value;
    logic                  out_overflow;

    modport master (
        output in_valid, in_mode, in_product,
        output in_regdest, in_negative, in_zero,
        input  in_ready,
        input  out_valid, out_regdest, out_writereg,
        input  out_value, out_overflow,
        output out_ready
    );

    modport slave (
        input  in_valid, in_mode, in_product,
        input  in_regdest, in_negative, in_zero,
        output in_ready,
        output out_valid, out_regdest, out_writereg,
        output out_value, out_overflow,
        input  out_ready
    );

endinterface

// File: rtl/mult_wb_fifo.sv
// Synchronous FIFO for writeback entries; head reads
// as zero while empty.
module mult_wb_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // depth is a power of two, so pointers wrap naturally
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mult_wb_stage.sv
// Multiplier writeback stage: sign fix-up, overflow
// detection and a small buffer ahead of the write port.
module mult_wb_stage
    import mult_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_mode,
    input  logic [2*DATA_W-1:0] in_product,
    input  logic [REG_W-1:0]    in_regdest,
    input  logic                in_negative,
    input  logic                in_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REG_W-1:0]    out_regdest,
    output logic                out_writereg,
    output logic [DATA_W-1:0]   out_value,
    output logic                out_overflow,
    input  logic                ovf_clear,
    output logic [15:0]         ovf_count
);

    localparam int PW = 2 * DATA_W;

    typedef struct packed {
        logic [REG_W-1:0]  regdest;
        logic              writereg;
        logic [DATA_W-1:0] value;
        logic              overflow;
    } entry_t;

    localparam int EW = $bits(entry_t);

    mode_e             w_mode;
    logic [PW-1:0]     w_r;
    logic [DATA_W:0]   w_mul_top;
    logic              w_mul_ovf;
    logic [DATA_W-1:0] w_val;
    logic              w_ovf;
    logic              w_rsvd;
    logic              w_ovf_eff;
    entry_t            w_entry;
    entry_t            w_head;
    logic [EW-1:0]     w_head_raw;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_pop;
    logic              r_rdy;
    logic [15:0]       r_ovf_count;

    assign w_mode    = mode_e'(in_mode);
    assign w_r       = in_negative ? (~in_product + PW'(1))
                                   : in_product;
    assign w_mul_top = w_r[PW-1:DATA_W-1];
    assign w_mul_ovf = !((&w_mul_top) || !(|w_mul_top));
    assign w_rsvd    = (w_mode == MODE_RSVD);
    assign w_ovf_eff = w_ovf && !in_zero && !w_rsvd;

    always_comb begin
        w_val = '0;
        w_ovf = 1'b0;
        case (w_mode)
            MODE_MUL: begin
                w_val = w_r[DATA_W-1:0];
                w_ovf = w_mul_ovf;
            end
            MODE_MULH: begin
                w_val = w_r[PW-1:DATA_W];
            end
            MODE_MULU: begin
                w_val = in_product[DATA_W-1:0];
                w_ovf = |in_product[PW-1:DATA_W];
            end
            default: begin
                w_val = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    // zero operand wins over sign and overflow
    always_comb begin
        w_entry = '0;
        if (w_rsvd) begin
            w_entry = '0;
        end else if (in_zero) begin
            w_entry.writereg = 1'b1;
            w_entry.regdest  = in_regdest;
        end else if (w_ovf_eff) begin
            w_entry.overflow = 1'b1;
        end else begin
            w_entry.writereg = 1'b1;
            w_entry.regdest  = in_regdest;
            w_entry.value    = w_val;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end

    assign in_ready = r_rdy && !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    mult_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_accept),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_data  (w_head_raw),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head       = entry_t'(w_head_raw);
    assign out_valid    = !w_empty;
    assign out_regdest  = w_head.regdest;
    assign out_writereg = w_head.writereg;
    assign out_value    = w_head.value;
    assign out_overflow = w_head.overflow;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ovf_count <= '0;
        end else if (ovf_clear) begin
            r_ovf_count <= '0;
        end else if (w_accept && w_ovf_eff
                     && r_ovf_count != 16'hFFFF) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_mult_wb_stage.sv
// Directed vector bench for mult_wb_stage.
module tb_mult_wb_stage;
    import mult_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ovf_clear = 1'b0;
    logic [15:0] ovf_count;

    always #5 clock = ~clock;

    mult_wb_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

    mult_wb_stage #(
        .DATA_W     (32),
        .REG_W      (5),
        .FIFO_DEPTH (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (bus.in_valid),
        .in_ready     (bus.in_ready),
        .in_mode      (bus.in_mode),
        .in_product   (bus.in_product),
        .in_regdest   (bus.in_regdest),
        .in_negative  (bus.in_negative),
        .in_zero      (bus.in_zero),
        .out_valid    (bus.out_valid),
        .out_ready    (bus.out_ready),
        .out_regdest  (bus.out_regdest),
        .out_writereg (bus.out_writereg),
        .out_value    (bus.out_value),
        .out_overflow (bus.out_overflow),
        .ovf_clear    (ovf_clear),
        .ovf_count    (ovf_count)
    );

    typedef struct {
        mode_e       mode;
        logic [63:0] prod;
        logic        neg;
        logic        zero;
        logic [4:0]  rd;
        wb_entry_t   exp;
    } vec_t;

    vec_t vecs [12];
    int   total = 0;
    int   bad = 0;
    int   n_ovf = 0;

    function automatic wb_entry_t ent(input logic [4:0] rd,
                                      input logic wr,
                                      input logic [31:0] val,
                                      input logic ovf);
        wb_entry_t e;
        e.regdest  = rd;
        e.writereg = wr;
        e.value    = val;
        e.overflow = ovf;
        return e;
    endfunction

    function automatic wb_entry_t head();
        return ent(bus.out_regdest, bus.out_writereg,
                   bus.out_value, bus.out_overflow);
    endfunction

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input mode_e m, input logic [63:0] p,
                         input logic n, input logic z,
                         input logic [4:0] rd);
        bus.in_valid    = 1'b1;
        bus.in_mode     = m;
        bus.in_product  = p;
        bus.in_negative = n;
        bus.in_zero     = z;
        bus.in_regdest  = rd;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_mode     = 2'b00;
        bus.in_product  = '0;
        bus.in_regdest  = '0;
        bus.in_negative = 1'b0;
        bus.in_zero     = 1'b0;
        bus.out_ready   = 1'b0;

        vecs[0]  = '{MODE_MUL,  64'd42, 1'b0, 1'b0, 5'd3,
                     ent(5'd3, 1'b1, 32'h0000002A, 1'b0)};
        vecs[1]  = '{MODE_MUL,  64'h80000000, 1'b1, 1'b0, 5'd4,
                     ent(5'd4, 1'b1, 32'h80000000, 1'b0)};
        vecs[2]  = '{MODE_MUL,  64'h80000000, 1'b0, 1'b0, 5'd5,
                     ent(5'd0, 1'b0, 32'h0, 1'b1)};
        vecs[3]  = '{MODE_MULH, 64'd1, 1'b1, 1'b0, 5'd6,
                     ent(5'd6, 1'b1, 32'hFFFFFFFF, 1'b0)};
        vecs[4]  = '{MODE_MULU, 64'h1_00000000, 1'b0, 1'b0, 5'd7,
                     ent(5'd0, 1'b0, 32'h0, 1'b1)};
        vecs[5]  = '{MODE_MUL,  64'h1234, 1'b1, 1'b1, 5'd8,
                     ent(5'd8, 1'b1, 32'h0, 1'b0)};
        vecs[6]  = '{MODE_RSVD, 64'd5, 1'b0, 1'b0, 5'd9,
                     ent(5'd0, 1'b0, 32'h0, 1'b0)};
        vecs[7]  = '{MODE_MULU, 64'hFFFFFFFF, 1'b1, 1'b0, 5'd10,
                     ent(5'd10, 1'b1, 32'hFFFFFFFF, 1'b0)};
        vecs[8]  = '{MODE_MULH, 64'h2_00000000, 1'b0, 1'b0, 5'd11,
                     ent(5'd11, 1'b1, 32'h2, 1'b0)};
        vecs[9]  = '{MODE_MUL,  64'd5, 1'b1, 1'b0, 5'd12,
                     ent(5'd12, 1'b1, 32'hFFFFFFFB, 1'b0)};
        vecs[10] = '{MODE_MULH, 64'hDEADBEEF_00000001, 1'b0,
                     1'b1, 5'd13,
                     ent(5'd13, 1'b1, 32'h0, 1'b0)};
        vecs[11] = '{MODE_MUL,  64'h1_00000000, 1'b1, 1'b0, 5'd14,
                     ent(5'd0, 1'b0, 32'h0, 1'b1)};

        repeat (2) @(negedge clock);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_ovf_count", 64'(ovf_count), 64'd0);
        check("rst_head", 64'(head()), 64'd0);

        reset = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_empty", 64'(bus.out_valid), 64'd0);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].mode, vecs[i].prod, vecs[i].neg,
                  vecs[i].zero, vecs[i].rd);
            if (vecs[i].exp.overflow) n_ovf++;
            @(posedge clock);
            @(negedge clock);
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i),
                  64'(bus.out_valid), 64'd1);
            check($sformatf("vec%0d_entry", i),
                  64'(head()), 64'(vecs[i].exp));
            check($sformatf("vec%0d_ovf_count", i),
                  64'(ovf_count), 64'(n_ovf));
            @(posedge clock);
            @(negedge clock);
        end
        check("drained", 64'(bus.out_valid), 64'd0);

        // backpressure: A,B fill the buffer, C waits
        bus.out_ready = 1'b0;
        drive(MODE_MUL, 64'h11, 1'b0, 1'b0, 5'd1);
        @(posedge clock);
        @(negedge clock);
        drive(MODE_MUL, 64'h22, 1'b0, 1'b0, 5'd2);
        @(posedge clock);
        @(negedge clock);
        check("bp_full_ready", 64'(bus.in_ready), 64'd0);
        check("bp_head_A", 64'(head()),
              64'(ent(5'd1, 1'b1, 32'h11, 1'b0)));
        drive(MODE_MUL, 64'h33, 1'b0, 1'b0, 5'd3);
        @(posedge clock);
        @(negedge clock);
        check("bp_C_held", 64'(bus.in_ready), 64'd0);
        check("bp_still_A", 64'(bus.out_value), 64'h11);
        bus.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("bp_head_B", 64'(head()),
              64'(ent(5'd2, 1'b1, 32'h22, 1'b0)));
        check("bp_ready_after_pop", 64'(bus.in_ready), 64'd1);
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        check("bp_head_C", 64'(head()),
              64'(ent(5'd3, 1'b1, 32'h33, 1'b0)));
        check("bp_occupancy_kept", 64'(bus.out_valid), 64'd1);
        check("bp_not_full", 64'(bus.in_ready), 64'd1);
        @(posedge clock);
        @(negedge clock);
        check("bp_empty", 64'(bus.out_valid), 64'd0);
        check("bp_empty_value", 64'(bus.out_value), 64'd0);
        check("bp_ovf_count", 64'(ovf_count), 64'(n_ovf));

        // overflow accept with and without a clear
        drive(MODE_MUL, 64'h80000000, 1'b0, 1'b0, 5'd5);
        @(posedge clock);
        @(negedge clock);
        check("ovf_incr", 64'(ovf_count), 64'(n_ovf + 1));
        ovf_clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ovf_clear = 1'b0;
        bus.in_valid = 1'b0;
        check("ovf_clear_wins", 64'(ovf_count), 64'd0);
        @(posedge clock);
        @(negedge clock);

        // reset while an entry is buffered
        bus.out_ready = 1'b0;
        drive(MODE_MULU, 64'h5_00000000, 1'b0, 1'b0, 5'd9);
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        check("mid_buffered", 64'(bus.out_valid), 64'd1);
        check("mid_ovf_count", 64'(ovf_count), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_ovf", 64'(ovf_count), 64'd0);
        check("mid_rst_head", 64'(head()), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rel_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rel_empty", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
